i2s_mem_controller: RTL and testbench

- Upstream feeder for the I2S serializer.
- Buffers 32-bit sample words written by the bus/DMA side in a synchronous FIFO.
- Serves one 24-bit sample plus its L/R flag per request over a four-phase request/ack handshake.
- The serializer's request originates in the i2s_clock domain. This block synchronizes it into clk, so the handshake is safe across domains.

---
 rtl/i2s_mem_controller.sv | 143 ++++++++++++++
 tb/tb_i2s_mem_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mem_controller.sv
// Sample FIFO feeding the I2S serializer: bus writes 32-bit words, the serializer
// pulls one 24-bit sample plus L/R flag per four-phase request/ack handshake.
module i2s_mem_controller #(
  parameter int ADDR_WIDTH = 6,
  parameter int LOW_WATER  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  clear_status,
  input  logic                  wr_stb,
  input  logic [31:0]           wr_data,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_low,
  output logic                  underflow,
  output logic                  overflow,
  input  logic                  audio_data_request,
  output logic                  audio_data_ack,
  output logic [23:0]           audio_data,
  output logic                  audio_lr_bit
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACK, STARVE} state_t;

  state_t                state;
  logic                  req_meta;
  logic                  req_s;
  logic [24:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [24:0]           head;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  unused;

  assign unused     = ^wr_data[30:24];
  assign full       = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty      = (count == '0);
  assign wr_ready   = !full;
  assign fifo_low   = (count <= (ADDR_WIDTH+1)'(LOW_WATER));
  assign fifo_count = count;
  assign head       = mem[rd_ptr];

  // A flush cycle neither pops nor serves; the request is picked up next cycle.
  assign pop     = enable && req_s && !empty && !flush && (state == IDLE || state == STARVE);
  assign push    = wr_stb && (!full || pop) && !flush;
  assign ovf_evt = wr_stb && full && !pop && !flush;
  assign udf_evt = enable && req_s && empty && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= audio_data_request;
      req_s    <= req_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (push && !pop)      count <= count + (ADDR_WIDTH+1)'(1);
      else if (pop && !push) count <= count - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_data[31], wr_data[23:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      audio_data_ack <= 1'b0;
      audio_data     <= '0;
      audio_lr_bit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            audio_data     <= head[23:0];
            audio_lr_bit   <= head[24];
            audio_data_ack <= 1'b1;
            state          <= ACK;
          end else if (udf_evt) begin
            state <= STARVE;
          end
        end
        STARVE: begin
          if (!enable || !req_s) begin
            state <= IDLE;
          end else if (pop) begin
            audio_data     <= head[23:0];
            audio_lr_bit   <= head[24];
            audio_data_ack <= 1'b1;
            state          <= ACK;
          end
        end
        ACK: begin
          if (!enable || !req_s) begin
            audio_data_ack <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          audio_data_ack <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  // Set events beat clear_status when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underflow <= udf_evt || (underflow && !clear_status);
      overflow  <= ovf_evt || (overflow && !clear_status);
    end
  end

endmodule

// File: tb/tb_i2s_mem_controller.sv
// Directed-plus-random bench for i2s_mem_controller; a queue models the FIFO contents.
module tb_i2s_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        clear_status = 1'b0;
  logic        wr_stb = 1'b0;
  logic [31:0] wr_data = '0;
  logic        audio_data_request = 1'b0;
  logic        wr_ready;
  logic [6:0]  fifo_count;
  logic        fifo_low;
  logic        underflow;
  logic        overflow;
  logic        audio_data_ack;
  logic [23:0] audio_data;
  logic        audio_lr_bit;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];

  i2s_mem_controller #(.ADDR_WIDTH(6), .LOW_WATER(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .clear_status(clear_status), .wr_stb(wr_stb), .wr_data(wr_data),
    .wr_ready(wr_ready), .fifo_count(fifo_count), .fifo_low(fifo_low),
    .underflow(underflow), .overflow(overflow),
    .audio_data_request(audio_data_request), .audio_data_ack(audio_data_ack),
    .audio_data(audio_data), .audio_lr_bit(audio_lr_bit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [31:0] w);
    wr_stb  = 1'b1;
    wr_data = w;
    tick();
    wr_stb  = 1'b0;
    if (q.size() < 64) q.push_back(w);
  endtask

  task automatic raise_req(output int lat);
    audio_data_request = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!audio_data_ack && lat < 12);
  endtask

  task automatic drop_req();
    int n;
    audio_data_request = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (audio_data_ack && n < 12);
    chk("ack_fall", {31'd0, audio_data_ack}, 32'd0);
  endtask

  task automatic serve_one(input string tag);
    logic [31:0] exp;
    int lat;
    exp = q.pop_front();
    raise_req(lat);
    chk({tag, "_lat"}, lat, 32'd3);
    chk({tag, "_data"}, {8'd0, audio_data}, {8'd0, exp[23:0]});
    chk({tag, "_lr"}, {31'd0, audio_lr_bit}, {31'd0, exp[31]});
    drop_req();
    chk({tag, "_count"}, {25'd0, fifo_count}, q.size());
    chk({tag, "_low"}, {31'd0, fifo_low}, {31'd0, q.size() <= 16});
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] exp;
    int lat;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, audio_data_ack}, 32'd0);
    chk("rst_data", {8'd0, audio_data}, 32'd0);
    chk("rst_count", {25'd0, fifo_count}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_low", {31'd0, fifo_low}, 32'd1);
    chk("rst_flags", {30'd0, underflow, overflow}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // Two fixed words, served in order
    write_word(32'h8012_3456);
    write_word(32'h0065_4321);
    chk("two_count", {25'd0, fifo_count}, 32'd2);
    serve_one("first");
    serve_one("second");

    // Empty request: set event coinciding with clear_status wins
    audio_data_request = 1'b1;
    tick();
    tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("udf_set_wins", {31'd0, underflow}, 32'd1);
    chk("udf_no_ack", {31'd0, audio_data_ack}, 32'd0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    repeat (3) tick();
    chk("udf_once", {31'd0, underflow}, 32'd0);
    write_word(32'h0000_00AA);
    n = 0;
    while (!audio_data_ack && n < 12) begin
      tick();
      n++;
    end
    exp = q.pop_front();
    chk("starve_lat", n, 32'd1);
    chk("starve_data", {8'd0, audio_data}, {8'd0, exp[23:0]});
    drop_req();
    chk("starve_udf", {31'd0, underflow}, 32'd0);

    // Fill to full with random words, then overflow
    for (int i = 0; i < 64; i++) write_word($urandom);
    chk("full_ready", {31'd0, wr_ready}, 32'd0);
    chk("full_count", {25'd0, fifo_count}, 32'd64);
    chk("full_low", {31'd0, fifo_low}, 32'd0);
    wr_stb  = 1'b1;
    wr_data = $urandom;
    tick();
    wr_stb  = 1'b0;
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {25'd0, fifo_count}, 32'd64);

    // Write and pop in the same cycle while full
    audio_data_request = 1'b1;
    tick();
    tick();
    w       = $urandom;
    wr_stb  = 1'b1;
    wr_data = w;
    tick();
    wr_stb  = 1'b0;
    exp = q.pop_front();
    q.push_back(w);
    chk("wp_ack", {31'd0, audio_data_ack}, 32'd1);
    chk("wp_data", {8'd0, audio_data}, {8'd0, exp[23:0]});
    chk("wp_count", {25'd0, fifo_count}, 32'd64);
    drop_req();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("ovf_clear", {31'd0, overflow}, 32'd0);

    // Drain through the low-water boundary, checking every sample
    while (q.size() > 17) serve_one("drain");
    chk("low_at17", {31'd0, fifo_low}, 32'd0);
    serve_one("cross");
    chk("low_at16", {31'd0, fifo_low}, 32'd1);
    chk("count16", {25'd0, fifo_count}, 32'd16);
    while (q.size() > 10) serve_one("drain2");

    // Flush beats a simultaneous write
    flush   = 1'b1;
    wr_stb  = 1'b1;
    wr_data = $urandom;
    tick();
    flush   = 1'b0;
    wr_stb  = 1'b0;
    q.delete();
    chk("flush_count", {25'd0, fifo_count}, 32'd0);
    chk("flush_ready", {31'd0, wr_ready}, 32'd1);
    chk("flush_flags", {30'd0, underflow, overflow}, 32'd0);

    // Enable dropped during ACK discards the popped sample
    for (int i = 0; i < 3; i++) write_word($urandom);
    raise_req(lat);
    exp = q.pop_front();
    chk("en_lat", lat, 32'd3);
    chk("en_data", {8'd0, audio_data}, {8'd0, exp[23:0]});
    enable = 1'b0;
    tick();
    chk("en_ack_drop", {31'd0, audio_data_ack}, 32'd0);
    chk("en_count", {25'd0, fifo_count}, q.size());
    audio_data_request = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    repeat (3) tick();
    chk("en_idle_ack", {31'd0, audio_data_ack}, 32'd0);
    chk("en_idle_count", {25'd0, fifo_count}, q.size());
    serve_one("after_en");

    // Asynchronous reset in the middle of ACK
    for (int i = 0; i < 5; i++) write_word($urandom);
    raise_req(lat);
    exp = q.pop_front();
    chk("pre_rst_count", {25'd0, fifo_count}, q.size());
    chk("pre_rst_ack", {31'd0, audio_data_ack}, 32'd1);
    #2;
    rst_n = 1'b0;
    audio_data_request = 1'b0;
    #1;
    chk("arst_ack", {31'd0, audio_data_ack}, 32'd0);
    chk("arst_count", {25'd0, fifo_count}, 32'd0);
    chk("arst_ready", {31'd0, wr_ready}, 32'd1);
    chk("arst_data", {8'd0, audio_data}, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    w = $urandom;
    write_word(w);
    serve_one("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
